// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature generator: FSM states and the
// phase-index to {A,B} output pattern.
package quad_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    STEP = 2'd2
  } state_e;

  // {A,B} per phase index, index 0 in the low bits: 0:00 1:10 2:11 3:01.
  localparam logic [7:0] PHASE_AB = {2'b01, 2'b11, 2'b10, 2'b00};

  function automatic logic [1:0] phaseToAb(input logic [1:0] phase);
    return PHASE_AB[{phase, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/quad_encoder_gen_step_timer.sv
// Step-period divider: loads a count, decrements while enabled and flags
// expiry on the enabled cycle in which the count has reached zero.
module step_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [DIV_W-1:0] loadVal_i,
  input  logic             count_i,
  output logic             expire_o
);

  logic [DIV_W-1:0] count_q, count_d;

  assign expire_o = count_i && (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = loadVal_i;
    end else if (count_i && (count_q != '0)) begin
      count_d = count_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder pattern generator: emits a commanded number of A/B steps
// at a programmable rate and tracks the resulting signed position.
module quad_encoder_gen
  import quad_pkg::*;
#(
  parameter int STEP_W = 16,
  parameter int DIV_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0]  cmd_period,
  input  logic              abort,
  output logic              enc_a,
  output logic              enc_b,
  output logic              busy,
  output logic              done,
  output logic [31:0]       position
);

  state_e            state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic [1:0]        ab_q;
  logic [31:0]       position_q, position_d;
  logic [STEP_W-1:0] stepsLeft_q, stepsLeft_d;
  logic [DIV_W-1:0]  reload_q, reload_d;
  logic              reverse_q, reverse_d;
  logic              done_q, done_d;

  logic              cmdNonZero, accept, stepFire, lastStep;
  logic              timerLoad, timerCount, timerExpire;
  logic [DIV_W-1:0]  timerLoadVal, cmdReload;
  logic [STEP_W-1:0] cmdMag;

  // Two's-complement negate: the most negative count maps to 2^(STEP_W-1).
  assign cmdNonZero = (cmd_steps != '0);
  assign cmdMag     = cmd_steps[STEP_W-1] ? (~cmd_steps + STEP_W'(1)) : cmd_steps;
  assign cmdReload  = (cmd_period == '0) ? '0 : cmd_period - DIV_W'(1);
  assign lastStep   = (stepsLeft_q == STEP_W'(1));

  step_timer #(.DIV_W(DIV_W)) u_timer (
    .clk_i     (sys_clk),
    .rst_ni    (sys_rst_n),
    .load_i    (timerLoad),
    .loadVal_i (timerLoadVal),
    .count_i   (timerCount),
    .expire_o  (timerExpire)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort wins over both the divider expiry and a pending step.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && cmdNonZero) state_d = WAIT;
      WAIT: begin
        if (abort)            state_d = IDLE;
        else if (timerExpire) state_d = STEP;
      end
      STEP: begin
        if (abort || lastStep) state_d = IDLE;
        else                   state_d = WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready    = (state_q == IDLE) && sys_rst_n;
    busy         = (state_q == WAIT) || (state_q == STEP);
    accept       = cmd_valid && (state_q == IDLE);
    stepFire     = (state_q == STEP) && !abort;
    timerCount   = (state_q == WAIT);
    timerLoad    = (accept && cmdNonZero) || (stepFire && !lastStep);
    timerLoadVal = accept ? cmdReload : reload_q;
  end

  always_comb begin
    phase_d     = phase_q;
    position_d  = position_q;
    stepsLeft_d = stepsLeft_q;
    reload_d    = reload_q;
    reverse_d   = reverse_q;
    done_d      = 1'b0;
    if (accept) begin
      if (cmdNonZero) begin
        stepsLeft_d = cmdMag;
        reload_d    = cmdReload;
        reverse_d   = cmd_steps[STEP_W-1];
      end else begin
        done_d = 1'b1;
      end
    end else if (busy && abort) begin
      done_d = 1'b1;
    end else if (stepFire) begin
      phase_d     = reverse_q ? phase_q - 2'd1 : phase_q + 2'd1;
      position_d  = reverse_q ? position_q - 32'd1 : position_q + 32'd1;
      stepsLeft_d = stepsLeft_q - STEP_W'(1);
      done_d      = lastStep;
    end
  end

  // Phase is kept across commands; only reset returns it to zero.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      phase_q     <= 2'd0;
      ab_q        <= 2'b00;
      position_q  <= '0;
      stepsLeft_q <= '0;
      reload_q    <= '0;
      reverse_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      ab_q        <= phaseToAb(phase_d);
      position_q  <= position_d;
      stepsLeft_q <= stepsLeft_d;
      reload_q    <= reload_d;
      reverse_q   <= reverse_d;
      done_q      <= done_d;
    end
  end

  assign enc_a    = ab_q[1];
  assign enc_b    = ab_q[0];
  assign done     = done_q;
  assign position = position_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Self-checking bench for quad_encoder_gen: a command table plus hand-written
// abort, wrap and mid-command reset sequences, checked through an edge scoreboard.
module tb_quad_encoder_gen;

  typedef struct {
    logic        doReset;
    int          steps;
    int          period;
    logic [31:0] expPos;
    logic [1:0]  expAb;
  } vec_t;

  typedef struct {
    logic [1:0] ab;
    int         cyc;
  } edge_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic [15:0] cmd_period = '0;
  logic        cmd_ready, enc_a, enc_b, busy, done;
  logic [31:0] position;

  int          checks = 0;
  int          errors = 0;
  int          cycleCnt = 0;
  edge_t       edgeQ[$];
  int          doneQ[$];
  logic [1:0]  tbPhase = 2'd0;
  logic [31:0] tbPos = '0;
  logic [1:0]  prevAb = 2'b00;
  logic        monitorOn = 1'b0;
  vec_t        vecs[5];

  quad_encoder_gen #(.STEP_W(16), .DIV_W(16)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_steps  (cmd_steps),
    .cmd_period (cmd_period),
    .abort      (abort),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .busy       (busy),
    .done       (done),
    .position   (position)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cycleCnt <= cycleCnt + 1;

  function automatic logic [1:0] abOf(input logic [1:0] p);
    case (p)
      2'd0:    return 2'b00;
      2'd1:    return 2'b10;
      2'd2:    return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every AB change and every done pulse must match a queued expectation.
  logic [1:0] curAb;
  edge_t      curEdge;
  int         curDone;
  always @(negedge sys_clk) begin
    curAb = {enc_a, enc_b};
    if (curAb != prevAb) begin
      if (monitorOn) begin
        if (edgeQ.size() == 0) begin
          checkOutput("unexpected_edge", {30'd0, curAb}, {30'd0, prevAb});
        end else begin
          curEdge = edgeQ.pop_front();
          checkOutput("edge_ab", {30'd0, curAb}, {30'd0, curEdge.ab});
          checkOutput("edge_cycle", cycleCnt, curEdge.cyc);
        end
      end
      prevAb = curAb;
    end
    if (done) begin
      if (doneQ.size() == 0) begin
        checkOutput("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        curDone = doneQ.pop_front();
        checkOutput("done_cycle", cycleCnt, curDone);
      end
    end
  end

  // Drives one command and queues the edges/done the command should produce.
  task automatic applyStimulus(input int steps, input int period, input int maxEdges, output int accCyc);
    int mag;
    int per;
    edge_t e;
    @(posedge sys_clk); #1;
    checkOutput("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    per = (period == 0) ? 1 : period;
    mag = (steps < 0) ? -steps : steps;
    accCyc = cycleCnt + 1;
    if (mag == 0) doneQ.push_back(accCyc);
    for (int k = 1; k <= mag && k <= maxEdges; k++) begin
      tbPhase = (steps < 0) ? tbPhase - 2'd1 : tbPhase + 2'd1;
      tbPos   = (steps < 0) ? tbPos - 32'd1 : tbPos + 32'd1;
      e.ab  = abOf(tbPhase);
      e.cyc = accCyc + k * (per + 1);
      edgeQ.push_back(e);
      if (k == mag) doneQ.push_back(e.cyc);
    end
    cmd_steps  = steps[15:0];
    cmd_period = period[15:0];
    cmd_valid  = 1'b1;
    @(posedge sys_clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int maxCycles);
    int n;
    n = 0;
    while ((edgeQ.size() != 0 || doneQ.size() != 0) && n < maxCycles) begin
      @(posedge sys_clk); #1;
      n++;
    end
    if (edgeQ.size() != 0 || doneQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: %0d edges and %0d done pulses still pending, expected none",
               name, edgeQ.size(), doneQ.size());
      edgeQ.delete();
      doneQ.delete();
    end
    repeat (3) @(posedge sys_clk);
    #1;
  endtask

  task automatic doReset();
    monitorOn = 1'b0;
    edgeQ.delete();
    doneQ.delete();
    sys_rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    checkOutput("reset_ready", {31'd0, cmd_ready}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_ab", {30'd0, enc_a, enc_b}, 32'd0);
    checkOutput("reset_position", position, 32'd0);
    sys_rst_n = 1'b1;
    tbPhase = 2'd0;
    tbPos = '0;
    #1;
    checkOutput("ready_after_reset", {31'd0, cmd_ready}, 32'd1);
    monitorOn = 1'b1;
  endtask

  initial begin
    int acc;
    vecs[0] = '{1'b1,  4, 3, 32'd4,        2'b00};
    vecs[1] = '{1'b1, -2, 0, 32'hFFFFFFFE, 2'b11};
    vecs[2] = '{1'b0,  0, 5, 32'hFFFFFFFE, 2'b11};
    vecs[3] = '{1'b0,  3, 2, 32'd1,        2'b10};
    vecs[4] = '{1'b0, -5, 1, 32'hFFFFFFFC, 2'b00};

    doReset();

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].doReset) doReset();
      applyStimulus(vecs[i].steps, vecs[i].period, 1 << 30, acc);
      if (vecs[i].steps == 0) begin
        checkOutput("noop_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("noop_busy", {31'd0, busy}, 32'd0);
      end else begin
        checkOutput("cmd_busy", {31'd0, busy}, 32'd1);
      end
      waitDrain("vector", 200);
      checkOutput("vec_position", position, vecs[i].expPos);
      checkOutput("vec_ab", {30'd0, enc_a, enc_b}, {30'd0, vecs[i].expAb});
      checkOutput("vec_idle_busy", {31'd0, busy}, 32'd0);
    end

    // Abort while idle must do nothing: no done pulse, still ready.
    abort = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    abort = 1'b0;
    checkOutput("idle_abort_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("idle_abort_busy", {31'd0, busy}, 32'd0);

    // Abort just after the 5th edge of a long command.
    doReset();
    applyStimulus(100, 10, 5, acc);
    while (cycleCnt < acc + 55) begin
      @(posedge sys_clk); #1;
    end
    abort = 1'b1;
    doneQ.push_back(cycleCnt + 1);
    @(posedge sys_clk); #1;
    abort = 1'b0;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_ready", {31'd0, cmd_ready}, 32'd1);
    waitDrain("abort", 50);
    repeat (30) @(posedge sys_clk);
    #1;
    checkOutput("abort_position", position, 32'd5);
    checkOutput("abort_ab", {30'd0, enc_a, enc_b}, {30'd0, 2'b10});

    // Position wrap: seed the counter at the positive limit, then step once forward.
    force dut.position_q = 32'h7FFFFFFF;
    @(posedge sys_clk); #1;
    release dut.position_q;
    tbPos = 32'h7FFFFFFF;
    applyStimulus(1, 1, 1 << 30, acc);
    waitDrain("wrap", 50);
    checkOutput("wrap_position", position, 32'h80000000);
    checkOutput("wrap_ab", {30'd0, enc_a, enc_b}, {30'd0, 2'b11});

    // Reset in the middle of a command: no done, outputs back to their reset values.
    applyStimulus(10, 4, 1 << 30, acc);
    while (cycleCnt < acc + 12) begin
      @(posedge sys_clk); #1;
    end
    doReset();
    repeat (20) @(posedge sys_clk);
    #1;
    checkOutput("midrst_ab", {30'd0, enc_a, enc_b}, 32'd0);
    checkOutput("midrst_position", position, 32'd0);
    checkOutput("midrst_ready", {31'd0, cmd_ready}, 32'd1);

    // Normal operation after the mid-command reset.
    applyStimulus(2, 2, 1 << 30, acc);
    waitDrain("post_reset", 50);
    checkOutput("post_reset_position", position, 32'd2);
    checkOutput("post_reset_ab", {30'd0, enc_a, enc_b}, {30'd0, 2'b11});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
